// File: rtl/spi_cmd_pkg.sv
// Shared frame layout and FSM state type for the SPI command slave.
package spi_cmd_pkg;

    localparam int unsigned FrameW  = 72;
    localparam int unsigned HdrLen  = 8;
    localparam int unsigned AddrW   = 7;
    localparam int unsigned DataW   = 64;
    localparam int unsigned CntW    = 7;
    localparam int unsigned RwBit   = 71;
    localparam int unsigned AddrMsb = 70;
    localparam int unsigned AddrLsb = 64;

    typedef enum logic [1:0] {StIdle, StHdr, StData, StDone} state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a configurable reset value per bit.
module sync_2ff #(
    parameter int unsigned     Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_cmd_slave.sv
// SPI mode-0 command slave: 72-bit frames, writes pushed to a command FIFO, reads shifted out.
// Optional SPI_CMD_ERR_CNT_EN adds a saturating err_cnt output for aborted and dropped frames.
module spi_cmd_slave
    import spi_cmd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_sck,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_rw,
    output logic [AddrW-1:0] cmd_addr,
    output logic [DataW-1:0] cmd_wdata,
    output logic [AddrW-1:0] rd_addr,
    input  logic [DataW-1:0] rd_data,
    output logic             frame_drop
`ifdef SPI_CMD_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    logic [2:0] sync_s;
    logic       sck_s, cs_s, mosi_s;

    sync_2ff #(
        .Width   (3),
        .ResetVal(3'b010)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  ({spi_sck, spi_cs_n, spi_mosi}),
        .q_o  (sync_s)
    );

    assign {sck_s, cs_s, mosi_s} = sync_s;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [FrameW-1:0] shift_q, shift_d, shift_nx;
    logic [DataW-1:0]  tx_q, tx_d;
    logic              rw_q, rw_d;
    logic              load_tx_q, load_tx_d;
    logic              sck_prev_q;
    logic              cs_prev_q, cs_prev_d;
    logic [1:0]        warm_q;
    logic              miso_q, miso_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [AddrW-1:0]  cmd_addr_q, cmd_addr_d;
    logic [DataW-1:0]  cmd_wdata_q, cmd_wdata_d;
    logic [AddrW-1:0]  rd_addr_q, rd_addr_d;
    logic              frame_drop_q, frame_drop_d;
    logic              abort;
    logic              sck_rise, sck_fall;

    // The oldest bit falls off the top once the frame has been consumed.
    logic unused_shift_msb;
    assign unused_shift_msb = shift_q[FrameW-1];

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign shift_nx = {shift_q[FrameW-2:0], mosi_s};

    // cs_n only counts as "seen high" once the synchronizer holds real samples, so a
    // chip select already low when reset releases does not open a frame.
    assign cs_prev_d = cs_s & warm_q[1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        rw_d         = rw_q;
        load_tx_d    = 1'b0;
        miso_d       = miso_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        rd_addr_d    = rd_addr_q;
        frame_drop_d = 1'b0;
        abort        = 1'b0;

        if (cmd_valid_q && cmd_ready) cmd_valid_d = 1'b0;
        if (load_tx_q) tx_d = rd_data;

        if (cs_s) begin
            state_d = StIdle;
            miso_d  = 1'b0;
            abort   = (state_q == StHdr) || (state_q == StData);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_prev_q) begin
                        state_d = StHdr;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end
                StHdr: begin
                    if (sck_rise) begin
                        shift_d = shift_nx;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CntW'(HdrLen - 1)) begin
                            state_d = StData;
                            rw_d    = shift_nx[RwBit-DataW];
                            if (shift_nx[RwBit-DataW]) begin
                                rd_addr_d = shift_nx[AddrMsb-DataW:AddrLsb-DataW];
                                load_tx_d = 1'b1;
                            end
                        end
                    end
                end
                StData: begin
                    if (sck_rise) begin
                        shift_d = shift_nx;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CntW'(FrameW - 1)) begin
                            state_d = StDone;
                            if (!rw_q) begin
                                if (cmd_valid_q && !cmd_ready) begin
                                    frame_drop_d = 1'b1;
                                end else begin
                                    cmd_valid_d = 1'b1;
                                    cmd_addr_d  = shift_nx[AddrMsb:AddrLsb];
                                    cmd_wdata_d = shift_nx[DataW-1:0];
                                end
                            end
                        end
                    end
                    if (sck_fall) begin
                        miso_d = rw_q & tx_q[DataW-1];
                        if (rw_q) tx_d = {tx_q[DataW-2:0], 1'b0};
                    end
                end
                StDone: begin
                    if (sck_fall) miso_d = 1'b0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            shift_q      <= '0;
            tx_q         <= '0;
            rw_q         <= 1'b0;
            load_tx_q    <= 1'b0;
            sck_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b0;
            warm_q       <= 2'b00;
            miso_q       <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            rd_addr_q    <= '0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            rw_q         <= rw_d;
            load_tx_q    <= load_tx_d;
            sck_prev_q   <= sck_s;
            cs_prev_q    <= cs_prev_d;
            warm_q       <= {warm_q[0], 1'b1};
            miso_q       <= miso_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            rd_addr_q    <= rd_addr_d;
            frame_drop_q <= frame_drop_d;
        end
    end

`ifdef SPI_CMD_ERR_CNT_EN
    logic [7:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((abort || frame_drop_d) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= '0;
        else        err_q <= err_d;
    end

    assign err_cnt = err_q;
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

    assign spi_miso   = miso_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_rw     = 1'b0;
    assign cmd_addr   = cmd_addr_q;
    assign cmd_wdata  = cmd_wdata_q;
    assign rd_addr    = rd_addr_q;
    assign frame_drop = frame_drop_q;

endmodule

// File: doc/spi_cmd_slave.md
SPI_CMD_SLAVE -- requirements
Module: spi_cmd_slave

Interface
REQ-001 SHALL have port clk  input  1  system clock; all logic in this single domain.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port spi_sck  input  1  SPI clock (mode 0), asynchronous to clk.
REQ-004 SHALL have port spi_cs_n  input  1  chip select, active low, asynchronous.
REQ-005 SHALL have port spi_mosi  input  1  serial data in, MSB first.
REQ-006 SHALL have port spi_miso  output  1  serial data out, MSB first.
REQ-007 SHALL have port cmd_valid  output  1  write command to command FIFO valid.
REQ-008 SHALL have port cmd_ready  input  1  command FIFO can accept.
REQ-009 SHALL have port cmd_rw  output  1  always 0 on pushed commands (writes only).
REQ-010 SHALL have port cmd_addr  output  7  register address of pushed command.
REQ-011 SHALL have port cmd_wdata  output  64  write data of pushed command.
REQ-012 SHALL have port rd_addr  output  7  address for combinational register read port.
REQ-013 SHALL have port rd_data  input  64  register read data for rd_addr.
REQ-014 SHALL have port frame_drop  output  1  one-clk pulse when a complete write frame is discarded.

Function
REQ-015 SHALL sample spi_sck, spi_cs_n, spi_mosi through 2-flop synchronizers and detect SCK edges on the synchronized signal; supported SCK ≤ clk/8.
REQ-016 SHALL use frame = 72 bits: bit71 rw (1=read), bits70:64 addr, bits63:0 data.
REQ-017 SHALL implement states IDLE, HDR, DATA, DONE: IDLE→HDR on cs_n falling; HDR→DATA after 8th SCK rise; DATA→DONE after 72nd SCK rise; any state→IDLE on cs_n high.
REQ-018 SHALL shift MOSI into a 72-bit shift register on each SCK rising edge while cs_n low; 7-bit bit counter, saturating in DONE.
REQ-019 SHALL, on a write frame completing, assert cmd_valid on the clk following detection of the 72nd SCK rise, cmd_rw=0, cmd_addr/cmd_wdata from frame; hold all stable until cmd_valid && cmd_ready.
REQ-020 SHALL, if a write frame completes while cmd_valid is still pending, keep the pending command unchanged, discard the new frame and pulse frame_drop.
REQ-021 SHALL, on a read frame, drive rd_addr from header bits after the 8th SCK rise and latch rd_data into a 64-bit TX register one clk later; no FIFO push.
REQ-022 SHALL present TX bit63 on spi_miso at the 8th SCK falling edge and the next bit on each following falling edge; 64 bits total.
REQ-023 SHALL drive spi_miso=0 in IDLE, HDR, during write frames, and after 64 read bits.
REQ-024 SHALL discard a frame aborted (cs_n high) before 72 bits: no cmd_valid, no frame_drop; a pending cmd_valid is unaffected.
REQ-025 SHALL ignore SCK edges beyond 72 until cs_n goes high.
REQ-026 SHALL hold rd_addr at its last value between frames.

Reset
REQ-027 SHALL on rst_n low: state=IDLE, counters 0, shift/TX registers 0, cmd_valid=0, cmd_rw=0, cmd_addr=0, cmd_wdata=0, rd_addr=0, spi_miso=0, frame_drop=0, synchronizers to idle (cs_n=1, sck=0).
REQ-028 SHALL discard a frame in progress at reset; the first frame after release starts at the next cs_n falling edge.

Configuration
REQ-029 SHALL, with SPI_CMD_ERR_CNT_EN defined, add output err_cnt (8 bits, reset 0) incremented, saturating at 0xFF, on each aborted frame and each frame_drop; without it, no err_cnt port and no counter logic.

Structure
REQ-030 SHALL place frame width (72), field bit positions, header length (8) and the state enum in shared package spi_cmd_pkg.
REQ-031 SHALL instantiate sub-module sync_2ff (parameterized width, reset value) for the three input synchronizers.

Verification
REQ-032 SHALL cover: write rw=0 addr=0x0A data=0x0000_0000_1122_3344, cmd_ready=1 -> one cmd_valid pulse, cmd_addr=0x0A, cmd_wdata=0x1122_3344.
REQ-033 SHALL cover: read addr=0x7F, rd_data=0x6702 -> rd_addr=0x7F, MISO data phase yields 0x0000_0000_0000_6702, no cmd_valid.
REQ-034 SHALL cover: cs_n released after 40 bits -> no cmd_valid, err_cnt=1 (macro on), next full frame accepted normally.
REQ-035 SHALL cover: cmd_ready=0, two write frames (addr 0x00, then 0x04) -> cmd_valid holds addr 0x00, frame_drop pulses once, accepted when cmd_ready=1.
REQ-036 SHALL cover: rst_n asserted at bit 30 of a write frame -> all outputs at reset values, no cmd_valid; next frame addr=0x0B pushed correctly.
